// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings, FSM states
// and small request-classification helpers.
package load_store_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_LATCH = 3'd2,
        ST_WR    = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_e;

    function automatic logic f3Legal(input logic store, input logic [2:0] funct3);
        if (store) begin
            return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end
        return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

    // Halfword accesses drop ADDR[0], word accesses drop ADDR[1:0].
    function automatic logic [1:0] alignOffset(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return {offset[1], 1'b0};
            2'b10:   return 2'b00;
            default: return offset;
        endcase
    endfunction

    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] offset);
        return alignOffset(funct3, offset) != offset;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: extracts and extends load data from a RAM word and
// merges sub-word store data into a RAM word.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [XLEN-1:0] word_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [1:0]      offset_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] loadData_o,
    output logic [XLEN-1:0] storeWord_o
);

    logic [7:0]      byteLane;
    logic [15:0]     halfLane;
    logic [XLEN-1:0] laneMask;
    logic [XLEN-1:0] laneData;

    always_comb begin
        byteLane = 8'(word_i >> {offset_i, 3'b000});
        halfLane = 16'(word_i >> {offset_i[1], 4'b0000});
        case (funct3_i)
            F3_LB:   loadData_o = {{24{byteLane[7]}}, byteLane};
            F3_LH:   loadData_o = {{16{halfLane[15]}}, halfLane};
            F3_LBU:  loadData_o = {24'h0, byteLane};
            F3_LHU:  loadData_o = {16'h0, halfLane};
            default: loadData_o = word_i;
        endcase
    end

    // The store data is replicated across all lanes so only the mask needs shifting.
    always_comb begin
        case (funct3_i[1:0])
            2'b00: begin
                laneMask = 32'h0000_00FF << {offset_i, 3'b000};
                laneData = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                laneMask = 32'h0000_FFFF << {offset_i[1], 4'b0000};
                laneData = {2{wdata_i[15:0]}};
            end
            default: begin
                laneMask = 32'hFFFF_FFFF;
                laneData = wdata_i;
            end
        endcase
        storeWord_o = (word_i & ~laneMask) | (laneData & laneMask);
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-memory front end: FSM, request latch and registered RAM/response outputs.
// Define LSU_MISALIGN_TRAP_EN to report misaligned H/HU/SH/W accesses as errors.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_store_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic [ADDR_W-1:0] ram_address_o,
    output logic [31:0]       ram_data_in_o,
    output logic              ram_write_enable_o,
    input  logic [31:0]       ram_data_out_i
);

    lsu_state_e        state_q, state_d;
    logic              reqStore_q, reqStore_d;
    logic [2:0]        reqFunct3_q, reqFunct3_d;
    logic [1:0]        reqOffset_q, reqOffset_d;
    logic [31:0]       reqWdata_q, reqWdata_d;
    logic              ready_q, ready_d;
    logic              respValid_q, respValid_d;
    logic [31:0]       respRdata_q, respRdata_d;
    logic              respErr_q, respErr_d;
    logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
    logic [31:0]       ramDin_q, ramDin_d;
    logic              ramWe_q, ramWe_d;

    logic              alignTrap;
    logic [31:0]       loadData;
    logic [31:0]       storeWord;
    logic              unusedAddrHi;

    assign unusedAddrHi = ^req_addr_i[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign alignTrap = isMisaligned(req_funct3_i, req_addr_i[1:0]);
`else
    assign alignTrap = 1'b0;
`endif

    load_store_unit_align u_align (
        .word_i      (ram_data_out_i),
        .wdata_i     (reqWdata_q),
        .offset_i    (reqOffset_q),
        .funct3_i    (reqFunct3_q),
        .loadData_o  (loadData),
        .storeWord_o (storeWord)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            reqStore_q  <= 1'b0;
            reqFunct3_q <= 3'b000;
            reqOffset_q <= 2'b00;
            reqWdata_q  <= 32'h0;
            ready_q     <= 1'b1;
            respValid_q <= 1'b0;
            respRdata_q <= 32'h0;
            respErr_q   <= 1'b0;
            ramAddr_q   <= '0;
            ramDin_q    <= 32'h0;
            ramWe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            reqStore_q  <= reqStore_d;
            reqFunct3_q <= reqFunct3_d;
            reqOffset_q <= reqOffset_d;
            reqWdata_q  <= reqWdata_d;
            ready_q     <= ready_d;
            respValid_q <= respValid_d;
            respRdata_q <= respRdata_d;
            respErr_q   <= respErr_d;
            ramAddr_q   <= ramAddr_d;
            ramDin_q    <= ramDin_d;
            ramWe_q     <= ramWe_d;
        end
    end

    // Outputs are registered, so each output's value for the next state is decided here.
    always_comb begin
        state_d     = state_q;
        reqStore_d  = reqStore_q;
        reqFunct3_d = reqFunct3_q;
        reqOffset_d = reqOffset_q;
        reqWdata_d  = reqWdata_q;
        respValid_d = 1'b0;
        respRdata_d = respRdata_q;
        respErr_d   = respErr_q;
        ramAddr_d   = ramAddr_q;
        ramDin_d    = ramDin_q;
        ramWe_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    reqStore_d  = req_store_i;
                    reqFunct3_d = req_funct3_i;
                    reqOffset_d = alignOffset(req_funct3_i, req_addr_i[1:0]);
                    reqWdata_d  = req_wdata_i;
                    respRdata_d = 32'h0;
                    respErr_d   = 1'b0;
                    if (!f3Legal(req_store_i, req_funct3_i) || alignTrap) begin
                        state_d     = ST_RESP;
                        respValid_d = 1'b1;
                        respErr_d   = 1'b1;
                    end else if (req_store_i && (req_funct3_i == F3_SW)) begin
                        state_d   = ST_WR;
                        ramAddr_d = req_addr_i[ADDR_W+1:2];
                        ramDin_d  = req_wdata_i;
                        ramWe_d   = 1'b1;
                    end else begin
                        state_d   = ST_RD;
                        ramAddr_d = req_addr_i[ADDR_W+1:2];
                    end
                end
            end
            ST_RD: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (reqStore_q) begin
                    state_d  = ST_WR;
                    ramDin_d = storeWord;
                    ramWe_d  = 1'b1;
                end else begin
                    state_d     = ST_RESP;
                    respValid_d = 1'b1;
                    respRdata_d = loadData;
                end
            end
            ST_WR: begin
                state_d     = ST_RESP;
                respValid_d = 1'b1;
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                respRdata_d = 32'h0;
                respErr_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    assign req_ready_o        = ready_q;
    assign resp_valid_o       = respValid_q;
    assign resp_rdata_o       = respRdata_q;
    assign resp_err_o         = respErr_q;
    assign ram_address_o      = ramAddr_q;
    assign ram_data_in_o      = ramDin_q;
    assign ram_write_enable_o = ramWe_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a word RAM and a byte-array reference model.
module tb_load_store_unit;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              reset;
   logic              reqValid;
   logic              reqReady;
   logic              reqStore;
   logic [2:0]        reqFunct3;
   logic [31:0]       reqAddr;
   logic [31:0]       reqWdata;
   logic              respValid;
   logic [31:0]       respRdata;
   logic              respErr;
   logic [ADDR_W-1:0] ramAddress;
   logic [31:0]       ramDataIn;
   logic              ramWriteEnable;
   logic [31:0]       ramDataOut;

   logic [31:0]       ram [0:1023];
   logic [7:0]        modelBytes [0:4095];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(ADDR_W)) dut (
      .clk_i              (clk),
      .reset_i            (reset),
      .req_valid_i        (reqValid),
      .req_ready_o        (reqReady),
      .req_store_i        (reqStore),
      .req_funct3_i       (reqFunct3),
      .req_addr_i         (reqAddr),
      .req_wdata_i        (reqWdata),
      .resp_valid_o       (respValid),
      .resp_rdata_o       (respRdata),
      .resp_err_o         (respErr),
      .ram_address_o      (ramAddress),
      .ram_data_in_o      (ramDataIn),
      .ram_write_enable_o (ramWriteEnable),
      .ram_data_out_i     (ramDataOut)
   );

   // Synchronous RAM: write on WE, read data registered one cycle after the address.
   always @(posedge clk) begin
      if (ramWriteEnable) ram[ramAddress] <= ramDataIn;
      ramDataOut <= ram[ramAddress];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] modelWord(input int idx);
      return {modelBytes[4*idx+3], modelBytes[4*idx+2], modelBytes[4*idx+1], modelBytes[4*idx]};
   endfunction

   // Reference model: byte-addressed little-endian memory with access-size rules.
   task automatic modelRequest(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, output int lat, output logic [31:0] rd,
                               output logic err, output int weCount);
      int size;
      int base;
      logic legal;
      logic [31:0] val;
      case (f3[1:0])
         2'b00:   size = 1;
         2'b01:   size = 2;
         2'b10:   size = 4;
         default: size = 0;
      endcase
      legal = (size != 0) && !(f3[2] && (st || size == 4));
      base = int'(addr & 32'h0000_0FFF);
`ifdef LSU_MISALIGN_TRAP_EN
      if (legal && (base % size) != 0) legal = 1'b0;
`endif
      lat = 1; rd = 32'h0; err = 1'b1; weCount = 0;
      if (!legal) return;
      base = base - (base % size);
      err = 1'b0;
      if (!st) begin
         val = 32'h0;
         for (int i = 0; i < size; i++) val = val | (32'(modelBytes[base+i]) << (8*i));
         if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
         rd = val;
         lat = 3;
      end else begin
         for (int i = 0; i < size; i++) modelBytes[base+i] = 8'(wd >> (8*i));
         lat = (size == 4) ? 2 : 4;
         weCount = 1;
      end
   endtask

   // Issue one request, follow it to its response and compare with the model.
   task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd);
      int expLat, expWe, lat, weSeen, waitCycles, widx;
      logic [31:0] expRdata;
      logic expErr;
      bit done;
      modelRequest(st, f3, addr, wd, expLat, expRdata, expErr, expWe);
      widx = int'(addr[11:2]);
      @(negedge clk);
      waitCycles = 0;
      while (!reqReady && waitCycles < 20) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("ready_idle", {31'b0, reqReady}, 32'd1);
      reqValid = 1'b1; reqStore = st; reqFunct3 = f3; reqAddr = addr; reqWdata = wd;
      @(posedge clk);
      #1;
      reqValid = 1'b0; reqStore = 1'($urandom); reqFunct3 = 3'($urandom);
      reqAddr = $urandom; reqWdata = $urandom;
      @(negedge clk);
      checkOutput("ready_busy", {31'b0, reqReady}, 32'd0);
      lat = 1; weSeen = 0; done = 1'b0;
      while (!done && lat <= 20) begin
         if (ramWriteEnable) weSeen++;
         if (respValid) done = 1'b1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      if (!done) begin
         checkOutput("resp_timeout", 32'd0, 32'd1);
      end else begin
         checkOutput("latency", 32'(lat), 32'(expLat));
         checkOutput("rdata", respRdata, expRdata);
         checkOutput("err", {31'b0, respErr}, {31'b0, expErr});
         checkOutput("we_cycles", 32'(weSeen), 32'(expWe));
      end
      checkOutput("ram_word", ram[widx], modelWord(widx));
   endtask

   initial begin
      logic [31:0] w;
      int respSeen;
      for (int i = 0; i < 1024; i++) begin
         w = $urandom;
         ram[i] = w;
         for (int b = 0; b < 4; b++) modelBytes[4*i+b] = 8'(w >> (8*b));
      end
      reset = 1'b1; reqValid = 1'b0; reqStore = 1'b0; reqFunct3 = 3'b000;
      reqAddr = 32'h0; reqWdata = 32'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checkOutput("rst_ready", {31'b0, reqReady}, 32'd1);
      checkOutput("rst_valid", {31'b0, respValid}, 32'd0);
      checkOutput("rst_err", {31'b0, respErr}, 32'd0);
      checkOutput("rst_rdata", respRdata, 32'd0);
      checkOutput("rst_we", {31'b0, ramWriteEnable}, 32'd0);
      checkOutput("rst_addr", 32'(ramAddress), 32'd0);
      checkOutput("rst_din", ramDataIn, 32'd0);

      applyStimulus(1'b1, 3'b010, 32'h0000_0004, 32'h1234_ABCD);
      applyStimulus(1'b0, 3'b010, 32'h0000_0004, 32'h0);
      applyStimulus(1'b0, 3'b000, 32'h0000_0005, 32'h0);
      applyStimulus(1'b0, 3'b100, 32'h0000_0005, 32'h0);
      applyStimulus(1'b0, 3'b001, 32'h0000_0006, 32'h0);
      applyStimulus(1'b0, 3'b101, 32'h0000_0004, 32'h0);
      applyStimulus(1'b1, 3'b000, 32'h0000_0007, 32'h0000_0077);
      applyStimulus(1'b1, 3'b001, 32'h0000_0004, 32'h0000_BEEF);
      checkOutput("word1_merge", ram[1], 32'h7734_BEEF);
      applyStimulus(1'b0, 3'b011, 32'h0000_0000, 32'h0);
      applyStimulus(1'b1, 3'b100, 32'h0000_0000, 32'hFFFF_FFFF);
      applyStimulus(1'b0, 3'b010, 32'h0000_0006, 32'h0);
      applyStimulus(1'b0, 3'b010, 32'h0000_1004, 32'h0);
      applyStimulus(1'b1, 3'b001, 32'hFFFF_F00B, 32'hCAFE_5A5A);

      // Reset lands in the LATCH cycle of an SB: no response and no write may follow.
      @(negedge clk);
      reqValid = 1'b1; reqStore = 1'b1; reqFunct3 = 3'b000; reqAddr = 32'h0000_0008;
      reqWdata = 32'h0000_00EE;
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("mid_rst_ready", {31'b0, reqReady}, 32'd1);
      checkOutput("mid_rst_valid", {31'b0, respValid}, 32'd0);
      checkOutput("mid_rst_we", {31'b0, ramWriteEnable}, 32'd0);
      respSeen = 0;
      repeat (4) begin
         @(negedge clk);
         if (respValid || ramWriteEnable) respSeen++;
      end
      checkOutput("mid_rst_quiet", 32'(respSeen), 32'd0);
      checkOutput("mid_rst_word2", ram[2], modelWord(2));

      for (int n = 0; n < 250; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         applyStimulus(1'($urandom), 3'($urandom),
                       ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
